video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Display timing generator for the 1024x768 VGA path. It produces the `pixel_row`, `pixel_column` and `video_on` stream that the 128x128 world-map scaler consumes, together with the horizontal and vertical sync pulses for the monitor. It sits between the pixel-clock domain logic and the map/colour lookup. Every output is registered and advances only on a pixel clock-enable.

## Interface
- `H_ACTIVE`, 1024: visible columns
- `H_FP`, 24: horizontal front porch, in pixels
- `H_SYNC`, 136: hsync width, in pixels
- `H_BP`, 160: horizontal back porch, in pixels
- `V_ACTIVE`, 768: visible rows
- `V_FP`, 3: vertical front porch, in lines
- `V_SYNC`, 6: vsync width, in lines
- `V_BP`, 29: vertical back porch, in lines
- `SYNC_POL`, 0: active level of both syncs (0 = negative)

Ports:
- `clock` in 1: single clock; all state changes on its rising edge
- `reset_n` in 1: reset, asynchronous, active-low
- `pix_ce` in 1: pixel advance enable; when low, all outputs hold
- `horiz_sync` out 1: horizontal sync, level set by SYNC_POL
- `vert_sync` out 1: vertical sync, level set by SYNC_POL
- `video_on` out 1: high when the current pixel is visible
- `pixel_row` out 12: current line, range 0..V_TOTAL-1
- `pixel_column` out 12: current pixel in the line, range 0..H_TOTAL-1
- `frame_start` out 1: present only with the macro (see Configuration)
- `frame_count` out 16: present only with the macro (see Configuration)

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344
  - V_TOTAL = 806
- Counters and advance:
  - Two 12-bit counters drive `pixel_column` and `pixel_row` directly.
  - On a clock edge with `pix_ce`=1, the column increments.
  - When the column is at H_TOTAL-1, it wraps to 0 and the row increments.
  - When the row is at V_TOTAL-1 and the column wraps, the row wraps to 0.
- Decoded outputs, all registered:
  - `video_on` = (col < H_ACTIVE) && (row < V_ACTIVE).
  - `horiz_sync` is active for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048, 1183].
  - `vert_sync` is active for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [771, 776], for whole lines, independent of column.
  - Syncs are inactive elsewhere, at level !SYNC_POL.
- Arithmetic:
  - Comparisons are unsigned 12-bit.
  - Parameters must satisfy H_TOTAL ≤ 4096 and V_TOTAL ≤ 4096.
  - Counters never exceed TOTAL-1.
- Reset values (asynchronous, while `reset_n`=0):
  - `pixel_column`=H_TOTAL-1 (1343), `pixel_row`=V_TOTAL-1 (805).
  - `video_on`=0.
  - `horiz_sync`=`vert_sync`=!SYNC_POL (1 with the defaults).
  - With the macro: `frame_start`=0, `frame_count`=0.
- After reset:
  - The first `pix_ce` edge after `reset_n` rises lands on (0,0) with `video_on`=1.
  - A reset asserted mid-frame forces the reset values immediately, independent of `clock`.
- `pix_ce` low:
  - Counters and all decoded outputs hold.
  - `frame_start` (macro) drops to 0.

## Timing
- Zero-cycle skew: `video_on`, `horiz_sync`, `vert_sync` and `pixel_row`/`pixel_column` update on the same edge. The decodes are computed from next-state counter values so they always describe the coordinate currently presented.
- One frame is 1344 x 806 = 1,083,264 enabled cycles; the period is exact and has no drift.
- A row change occurs on the same edge as the column 1343 → 0 transition.
- Downstream address logic sees a new coordinate once per `pix_ce`. Any latency it adds is its own and must be compensated there.

## Configuration
- Macro: `VIDEO_TIMING_GEN_FRAME_COUNT_EN`.
- When defined, two ports are added:
  - `frame_start`: a single-cycle pulse on the edge where the counters move from (1343,805) to (0,0).
  - `frame_count`: increments on that same edge and wraps from 65535 to 0.
- When undefined, both ports and their registers are absent and the behaviour is otherwise identical.

## Test plan
- Reset release with `pix_ce`=1:
  - During reset, required values are col=1343, row=805, `video_on`=0, syncs=1.
  - The first edge after release gives (0,0) with `video_on`=1.
- Free run for one line:
  - `video_on` falls at col=1024.
  - `horiz_sync`=0 for exactly cols 1048..1183 (136 cycles).
  - Row increments as col goes 1343 → 0.
- Free run for a full frame:
  - `vert_sync`=0 for rows 771..776, i.e. 6 x 1344 = 8064 cycles.
  - `video_on` stays 0 for rows 768..805.
  - The frame is 1,083,264 cycles.
- Toggle `pix_ce` 1-0-0-1 at col=500:
  - All outputs hold at col=500 for two cycles, then col=501.
- Assert `reset_n`=0 asynchronously at (700,400):
  - Outputs go to reset values before the next clock edge.
  - Restart is at (0,0).
- Macro defined, run 2 frames:
  - `frame_start` pulses exactly twice, each pulse 1 cycle wide, coincident with (0,0).
  - `frame_count` reads 2.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered column/row counters plus decoded video_on and syncs.
// Optional frame_start/frame_count ports are enabled by defining VIDEO_TIMING_GEN_FRAME_COUNT_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic [11:0] pixel_row,
  output logic [11:0] pixel_column
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] r_col;
  logic [11:0] r_row;
  logic        r_video_on;
  logic        r_hsync;
  logic        r_vsync;

  logic        w_col_wrap;
  logic        w_row_wrap;
  logic [11:0] w_col_nxt;
  logic [11:0] w_row_nxt;
  logic        w_video_on_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;

  // Decodes use the next coordinate so they line up with the counters they describe.
  always_comb begin
    w_col_wrap     = (r_col == H_LAST);
    w_row_wrap     = (r_row == V_LAST);
    w_col_nxt      = w_col_wrap ? 12'd0 : r_col + 12'd1;
    w_row_nxt      = r_row;
    if (w_col_wrap) begin
      w_row_nxt    = w_row_wrap ? 12'd0 : r_row + 12'd1;
    end
    w_video_on_nxt = (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);
    w_hsync_nxt    = ((w_col_nxt >= HS_FIRST) && (w_col_nxt <= HS_LAST)) ? SYNC_POL : !SYNC_POL;
    w_vsync_nxt    = ((w_row_nxt >= VS_FIRST) && (w_row_nxt <= VS_LAST)) ? SYNC_POL : !SYNC_POL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col      <= H_LAST;
      r_row      <= V_LAST;
      r_video_on <= 1'b0;
      r_hsync    <= !SYNC_POL;
      r_vsync    <= !SYNC_POL;
    end else if (pix_ce) begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_video_on <= w_video_on_nxt;
      r_hsync    <= w_hsync_nxt;
      r_vsync    <= w_vsync_nxt;
    end
  end

  assign pixel_column = r_col;
  assign pixel_row    = r_row;
  assign video_on     = r_video_on;
  assign horiz_sync   = r_hsync;
  assign vert_sync    = r_vsync;

`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
  logic        r_frame_start;
  logic [15:0] r_frame_count;
  logic        w_frame_wrap;

  // A frame begins on the enabled edge that moves the raster from the last pixel to (0,0).
  assign w_frame_wrap = pix_ce && w_col_wrap && w_row_wrap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: full-size instance for line-level timing, reduced-size instance for frame-level timing.
module tb_video_timing_gen;

  logic        clock;
  logic        reset_n;
  logic        pix_ce;

  logic        hs, vs, von;
  logic [11:0] row, col;
  logic        s_hs, s_vs, s_von;
  logic [11:0] s_row, s_col;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
  logic        fs, s_fs;
  logic [15:0] fc, s_fc;
`endif

  int n_chk;
  int n_pass;

  video_timing_gen u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .horiz_sync  (hs),
    .vert_sync   (vs),
    .video_on    (von),
    .pixel_row   (row),
    .pixel_column(col)
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    ,
    .frame_start (fs),
    .frame_count (fc)
`endif
  );

  // Small raster: H_TOTAL=16 (hsync cols 10..12), V_TOTAL=10 (vsync rows 7..8), positive syncs.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u_small (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .horiz_sync  (s_hs),
    .vert_sync   (s_vs),
    .video_on    (s_von),
    .pixel_row   (s_row),
    .pixel_column(s_col)
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    ,
    .frame_start (s_fs),
    .frame_count (s_fc)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int   steps;
    logic ce;
    int   col;
    int   row;
    logic von;
    logic hs;
    logic vs;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_main(input string tag, input int c, input int r, input int v, input int h, input int s);
    chk({tag, " col"}, int'(col), c);
    chk({tag, " row"}, int'(row), r);
    chk({tag, " video_on"}, int'(von), v);
    chk({tag, " hsync"}, int'(hs), h);
    chk({tag, " vsync"}, int'(vs), s);
  endtask

  task automatic chk_small(input string tag, input int c, input int r, input int v, input int h, input int s);
    chk({tag, " s_col"}, int'(s_col), c);
    chk({tag, " s_row"}, int'(s_row), r);
    chk({tag, " s_video_on"}, int'(s_von), v);
    chk({tag, " s_hsync"}, int'(s_hs), h);
    chk({tag, " s_vsync"}, int'(s_vs), s);
  endtask

  initial begin
    int hs_low, von_hi, s_vs_act, s_vs_bad, s_von_hi, s_hs_act;
    int fs_pulses, fs_origin;
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    pix_ce  = 1'b1;

    // Cumulative positions from (0,0); the default raster is 1344 x 806.
    vecs[0]  = '{1023, 1'b1, 1023, 0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1,    1'b1, 1024, 0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{23,   1'b1, 1047, 0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1,    1'b1, 1048, 0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{135,  1'b1, 1183, 0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1,    1'b1, 1184, 0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{159,  1'b1, 1343, 0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1,    1'b1, 0,    1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{5,    1'b0, 0,    1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{500,  1'b1, 500,  1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{2,    1'b0, 500,  1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1,    1'b1, 501,  1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk_main("reset", 1343, 805, 0, 1, 1);
    chk_small("reset", 15, 9, 0, 0, 0);
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    chk("reset frame_start", int'(s_fs), 0);
    chk("reset frame_count", int'(s_fc), 0);
`endif

    reset_n = 1'b1;
    tick(1'b1);
    chk_main("first", 0, 0, 1, 1, 1);
    chk_small("first", 0, 0, 1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vecs[i].steps; k++) tick(vecs[i].ce);
      chk_main($sformatf("vec%0d", i), vecs[i].col, vecs[i].row,
               int'(vecs[i].von), int'(vecs[i].hs), int'(vecs[i].vs));
    end

    // One whole line from (501,1).
    hs_low = 0;
    von_hi = 0;
    for (int k = 0; k < 1344; k++) begin
      tick(1'b1);
      if (!hs) hs_low++;
      if (von) von_hi++;
    end
    chk("line hsync low cycles", hs_low, 136);
    chk("line video_on cycles", von_hi, 1024);
    chk("line end col", int'(col), 501);
    chk("line end row", int'(row), 2);

    repeat (199) tick(1'b1);
    chk("pre-reset col", int'(col), 700);
    chk("pre-reset row", int'(row), 2);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    chk_main("async", 1343, 805, 0, 1, 1);
    chk_small("async", 15, 9, 0, 0, 0);
    @(posedge clock);
    #1;
    chk_main("held", 1343, 805, 0, 1, 1);

    reset_n = 1'b1;
    tick(1'b1);
    chk_main("restart", 0, 0, 1, 1, 1);
    chk_small("restart", 0, 0, 1, 0, 0);
    fs_pulses = 0;
    fs_origin = 0;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    if (s_fs) fs_pulses++;
    if (s_fs && s_col == 12'd0 && s_row == 12'd0) fs_origin++;
`endif

    // One complete small frame (160 enabled cycles).
    s_vs_act = 0;
    s_vs_bad = 0;
    s_von_hi = 0;
    s_hs_act = 0;
    for (int k = 0; k < 160; k++) begin
      tick(1'b1);
      if (s_vs) s_vs_act++;
      if (s_vs && !(s_row == 12'd7 || s_row == 12'd8)) s_vs_bad++;
      if (s_von) s_von_hi++;
      if (s_hs) s_hs_act++;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
      if (s_fs) fs_pulses++;
      if (s_fs && s_col == 12'd0 && s_row == 12'd0) fs_origin++;
`endif
    end
    chk("frame vsync cycles", s_vs_act, 32);
    chk("frame vsync outside rows", s_vs_bad, 0);
    chk("frame video_on cycles", s_von_hi, 48);
    chk("frame hsync cycles", s_hs_act, 30);
    chk_small("frame end", 0, 0, 1, 0, 0);
    chk("frame main col", int'(col), 160);
    chk("frame main row", int'(row), 0);
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    chk("frame_start pulses", fs_pulses, 2);
    chk("frame_start at origin", fs_origin, 2);
    chk("frame_count", int'(s_fc), 2);
    tick(1'b1);
    chk("frame_start width", int'(s_fs), 0);
    chk("frame_count hold", int'(s_fc), 2);
`endif

    tick(1'b0);
    chk("ce low s_col hold", int'(s_col), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
